// File: rtl/usb_if_pkg.sv
// Shared USB-interface definitions: arbiter state encodings and data-port count limits.
// No logic, so no latency; no flow control of its own.
package usb_if_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARB     = 2'd1;
  localparam logic [1:0] ST_STRT    = 2'd2;
  localparam logic [1:0] ST_WT_DONE = 2'd3;

  localparam int DP_MIN = 2;
  localparam int DP_MAX = 8;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first set request at or after ptr, wrapping modulo N.
// Purely combinational (zero cycles); vld low when no request is set.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          vld,
  output logic [IW-1:0] idx
);

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int ofs);
    int s;
    s = int'(base) + ofs;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  // Scan from furthest to nearest so the nearest request overwrites the rest.
  always_comb begin
    vld = 1'b0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[wrap_add(ptr, k)]) begin
        vld = 1'b1;
        idx = wrap_add(ptr, k);
      end
    end
  end

endmodule

// File: rtl/dp_arbtr_rr.sv
// Round-robin owner of the FX3 slave-FIFO bus across NUM_DP data-port engines, with watchdog.
// Grant one cycle after a request is seen in ARB; engines hold the bus until done or timeout.
module dp_arbtr_rr
  import usb_if_pkg::*;
#(
  parameter int                NUM_DP    = 4,
  parameter int                ADDR_W    = 2,
  parameter logic [NUM_DP-1:0] RD_MASK   = {{(NUM_DP-1){1'b0}}, 1'b1},
  parameter bit                SKIP_IDLE = 1'b1,
  parameter int                TIMEOUT   = 0
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [NUM_DP-1:0] req_i,
  output logic [NUM_DP-1:0] strt_o,
  input  logic [NUM_DP-1:0] done_i,
  output logic [NUM_DP-1:0] grant_o,
  output logic              tmo_o,
  input  logic [NUM_DP-1:0] SLWRn_i,
  input  logic [NUM_DP-1:0] PKTENDn_i,
  output logic [ADDR_W-1:0] SLADDR_o,
  output logic              SLOEn_o,
  output logic              SLCSn_o,
  output logic              SLWRn_o,
  output logic              PKTENDn_o
);

  localparam int IW = (NUM_DP > 1) ? $clog2(NUM_DP) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [1:0]        state_q;
  logic [IW-1:0]     g_q;
  logic [IW-1:0]     last_q;
  logic [CW-1:0]     cnt_q;
  logic              tmo_q;

  logic [IW-1:0]     ptr;
  logic [NUM_DP-1:0] cand_req;
  logic              pick_vld;
  logic [IW-1:0]     pick_idx;
  logic              expire;
  logic              granted;
  logic [NUM_DP-1:0] g_oh;

  // Legacy mode treats every port as requesting, giving a fixed 0..N-1 sequence.
  assign cand_req = SKIP_IDLE ? req_i : '1;
  assign ptr      = (last_q == IW'(NUM_DP - 1)) ? '0 : last_q + 1'b1;

  rr_pick #(
    .N  (NUM_DP),
    .IW (IW)
  ) u_pick (
    .req (cand_req),
    .ptr (ptr),
    .vld (pick_vld),
    .idx (pick_idx)
  );

  // cnt_q holds the number of WT_DONE cycles already elapsed.
  assign expire = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      g_q     <= '0;
      last_q  <= IW'(NUM_DP - 1);
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      case (state_q)
        ST_IDLE: state_q <= ST_ARB;
        ST_ARB: begin
          if (pick_vld) begin
            state_q <= ST_STRT;
            g_q     <= pick_idx;
            last_q  <= pick_idx;
          end
        end
        ST_STRT: begin
          state_q <= ST_WT_DONE;
          cnt_q   <= '0;
        end
        ST_WT_DONE: begin
          cnt_q <= cnt_q + 1'b1;
          if (done_i[g_q]) begin
            state_q <= ST_ARB;
            g_q     <= '0;
          end else if (expire) begin
            state_q <= ST_ARB;
            g_q     <= '0;
            tmo_q   <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign granted = (state_q == ST_STRT) || (state_q == ST_WT_DONE);
  assign g_oh    = NUM_DP'(1) << g_q;

  assign grant_o   = granted ? g_oh : '0;
  assign strt_o    = (state_q == ST_STRT) ? g_oh : '0;
  assign tmo_o     = tmo_q;
  assign SLCSn_o   = ~granted;
  assign SLADDR_o  = granted ? ADDR_W'(g_q) : '0;
  assign SLOEn_o   = granted ? ~RD_MASK[g_q] : 1'b1;
  assign SLWRn_o   = granted ? SLWRn_i[g_q] : 1'b1;
  assign PKTENDn_o = granted ? PKTENDn_i[g_q] : 1'b1;

endmodule

// File: tb/tb_dp_arbtr_rr.sv
// Bench for dp_arbtr_rr: a skip-idle instance with watchdog and a legacy fixed-sequence instance.
`timescale 1ns/1ps
module tb_dp_arbtr_rr;

  localparam int N = 4;
  localparam int TMO = 16;
  localparam logic [N-1:0] MDL_RD = 4'b0001;

  typedef struct {
    int port;
    bit tmo;
    int len;
  } xfer_t;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  logic rstn_i;

  logic [N-1:0] req_i, strt_o, done_i, grant_o, slwr_i, pkt_i;
  logic         tmo_o, sloe_o, slcs_o, slwr_o, pkt_o;
  logic [1:0]   sladdr_o;

  logic [N-1:0] l_req, l_strt, l_done, l_grant, l_slwr_i, l_pkt_i;
  logic         l_tmo, l_sloe, l_slcs, l_slwr_o, l_pkt_o;
  logic [1:0]   l_sladdr;

  dp_arbtr_rr #(.NUM_DP(N), .ADDR_W(2), .RD_MASK(4'b0001), .SKIP_IDLE(1'b1), .TIMEOUT(TMO)) u_dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .req_i(req_i), .strt_o(strt_o), .done_i(done_i),
    .grant_o(grant_o), .tmo_o(tmo_o), .SLWRn_i(slwr_i), .PKTENDn_i(pkt_i),
    .SLADDR_o(sladdr_o), .SLOEn_o(sloe_o), .SLCSn_o(slcs_o), .SLWRn_o(slwr_o), .PKTENDn_o(pkt_o)
  );

  dp_arbtr_rr #(.NUM_DP(N), .ADDR_W(2), .RD_MASK(4'b0001), .SKIP_IDLE(1'b0), .TIMEOUT(0)) u_leg (
    .clk_i(clk_i), .rstn_i(rstn_i), .req_i(l_req), .strt_o(l_strt), .done_i(l_done),
    .grant_o(l_grant), .tmo_o(l_tmo), .SLWRn_i(l_slwr_i), .PKTENDn_i(l_pkt_i),
    .SLADDR_o(l_sladdr), .SLOEn_o(l_sloe), .SLCSn_o(l_slcs), .SLWRn_o(l_slwr_o), .PKTENDn_o(l_pkt_o)
  );

  int n_chk = 0;
  int n_pass = 0;
  int leg_seen = 0;
  int model_last;
  logic [N-1:0] cur_req;
  xfer_t exp_q[$];
  int leg_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference arbitration rule: first requesting port after the last winner, wrapping.
  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int s = 1; s <= N; s++) begin
      if (r[(last + s) % N]) return (last + s) % N;
    end
    return -1;
  endfunction

  task automatic rst_chk(input string tag);
    chk({tag, "_grant"}, grant_o, 0);
    chk({tag, "_strt"}, strt_o, 0);
    chk({tag, "_tmo"}, tmo_o, 0);
    chk({tag, "_slcs"}, slcs_o, 1);
    chk({tag, "_sloe"}, sloe_o, 1);
    chk({tag, "_sladdr"}, sladdr_o, 0);
    chk({tag, "_slwr"}, slwr_o, 1);
    chk({tag, "_pkt"}, pkt_o, 1);
    chk({tag, "_leg_grant"}, l_grant, 0);
    chk({tag, "_leg_slcs"}, l_slcs, 1);
  endtask

  task automatic set_req(input logic [N-1:0] r);
    req_i   = r;
    cur_req = r;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_i);
      chk("idle_slcs", slcs_o, 1);
      chk("idle_grant", grant_o, 0);
    end
  endtask

  // One transfer: done in the k-th WT_DONE cycle (k=0: never), nxt is the request seen at release.
  task automatic xfer(input int k, input logic [N-1:0] nxt);
    int p, t, last_j;
    xfer_t e;
    p = pick(cur_req, model_last);
    model_last = p;
    e.port = p;
    e.tmo  = (k == 0);
    e.len  = (k == 0 ? TMO : k) + 1;
    exp_q.push_back(e);
    t = 0;
    do begin
      @(negedge clk_i);
      t++;
    end while (strt_o == 0 && t < 50);
    if (strt_o == 0) begin
      chk("strt_wait", 0, 1);
      return;
    end
    last_j = (k == 0) ? TMO : k;
    for (int j = 1; j <= last_j; j++) begin
      @(negedge clk_i);
      slwr_i = N'($urandom);
      pkt_i  = N'($urandom);
      done_i = (N'($urandom) | (N'(1) << ((p + 1) % N))) & ~(N'(1) << p);
      if ($urandom_range(0, 1) == 1) req_i[p] = 1'b0;
      if (j == last_j) begin
        if (k != 0) done_i[p] = 1'b1;
        req_i   = nxt;
        cur_req = nxt;
      end
      #1;
      chk("slwr_mux", slwr_o, slwr_i[p]);
      chk("pkt_mux", pkt_o, pkt_i[p]);
    end
    @(negedge clk_i);
    done_i = '0;
    slwr_i = '0;
    pkt_i  = '0;
    #1;
    chk("slwr_gated", slwr_o, 1);
    chk("pkt_gated", pkt_o, 1);
    slwr_i = '1;
    pkt_i  = '1;
  endtask

  // Scoreboard monitor: checks each grant against the queued expectation and its release.
  initial begin : mon
    bit act;
    int len;
    xfer_t e;
    act = 1'b0;
    len = 0;
    forever begin
      @(negedge clk_i);
      if (!rstn_i) begin
        act = 1'b0;
        continue;
      end
      if (strt_o != 0) begin
        if (exp_q.size() == 0) chk("strt_unexpected", strt_o, 0);
        else begin
          e = exp_q.pop_front();
          act = 1'b1;
          len = 0;
          chk("strt_port", strt_o, 1 << e.port);
          chk("sladdr", sladdr_o, e.port);
          chk("sloe", sloe_o, !MDL_RD[e.port]);
        end
      end
      if (act) begin
        if (grant_o != 0) begin
          len++;
          chk("grant_hold", grant_o, 1 << e.port);
          chk("slcs_low", slcs_o, 0);
          chk("tmo_quiet", tmo_o, 0);
        end else begin
          chk("xfer_len", len, e.len);
          chk("tmo_at_release", tmo_o, e.tmo);
          act = 1'b0;
        end
      end
    end
  end

  initial begin : leg_eng
    logic [N-1:0] s;
    l_done = '0;
    forever begin
      @(negedge clk_i);
      if (l_strt != 0) begin
        s = l_strt;
        repeat (3) @(negedge clk_i);
        l_done = s;
        @(negedge clk_i);
        l_done = '0;
      end
    end
  end

  initial begin : leg_mon
    int e;
    forever begin
      @(negedge clk_i);
      if (rstn_i && l_strt != 0 && leg_q.size() > 0) begin
        e = leg_q.pop_front();
        leg_seen++;
        chk("leg_strt", l_strt, 1 << e);
        chk("leg_sladdr", l_sladdr, e);
        chk("leg_sloe", l_sloe, !MDL_RD[e]);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL sim_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int p, t;
    xfer_t e;
    logic [N-1:0] nxt;
    rstn_i = 1'b0;
    req_i = '0; done_i = '0; slwr_i = '1; pkt_i = '1;
    l_req = '0; l_slwr_i = '1; l_pkt_i = '1;
    cur_req = '0;
    model_last = N - 1;
    for (int i = 0; i < 5; i++) leg_q.push_back(i % N);
    repeat (3) @(negedge clk_i);
    rst_chk("rst");
    rstn_i = 1'b1;

    idle(20);
    set_req(4'b1010);
    repeat (3) xfer(2, 4'b1010);
    xfer(2, 4'b0100);
    xfer(3, 4'b0101);
    xfer(2, 4'b0101);
    xfer(0, 4'b1111);
    xfer(TMO, 4'b1111);
    xfer(5, 4'b0011);

    for (int it = 0; it < 40; it++) begin
      t = $urandom_range(0, 9);
      nxt = ($urandom_range(0, 7) == 0) ? 4'b0000 : N'($urandom_range(1, 15));
      xfer((t == 0) ? 0 : (t == 1) ? TMO : $urandom_range(1, 6), nxt);
      if (cur_req == 0) begin
        idle(8);
        set_req(N'($urandom_range(1, 15)));
      end
    end

    // Reset in the middle of a transfer while the granted engine drives SLWRn low.
    p = pick(cur_req, model_last);
    e.port = p; e.tmo = 1'b0; e.len = 0;
    exp_q.push_back(e);
    t = 0;
    do begin
      @(negedge clk_i);
      t++;
    end while (strt_o == 0 && t < 50);
    chk("rst_xfer_strt", strt_o, 1 << p);
    @(negedge clk_i);
    slwr_i = '1;
    slwr_i[p] = 1'b0;
    #1;
    chk("pre_rst_slwr", slwr_o, 0);
    @(negedge clk_i);
    rstn_i = 1'b0;
    @(negedge clk_i);
    #1;
    chk("mid_rst_slwr", slwr_o, 1);
    chk("mid_rst_slcs", slcs_o, 1);
    chk("mid_rst_grant", grant_o, 0);
    @(negedge clk_i);
    rst_chk("rst2");
    slwr_i = '1;
    model_last = N - 1;
    set_req(4'b1111);
    rstn_i = 1'b1;
    xfer(2, 4'b0000);
    idle(3);

    chk("sb_empty", exp_q.size(), 0);
    chk("leg_grants", leg_seen, 5);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dp_arbtr_rr.md
# dp_arbtr_rr

Parametrised round-robin arbiter for the FX3 slave-FIFO data ports. It grants the shared GPIF-II bus to one of `NUM_DP` data-port engines at a time and drives the FX3 address, output-enable and chip-select strobes. It multiplexes the granted engine's write and packet-end strobes onto the bus. It sits between the data-port engines and the FX3 pad logic inside the USB interface, and adds over the fixed-sequence arbiter:

- request-based skipping
- per-port direction
- a transfer watchdog

## Interface
Parameters:
- `NUM_DP`, 4 — number of data ports, 2..8; must satisfy `NUM_DP <= 2**ADDR_W`.
- `ADDR_W`, 2 — width of `SLADDR_o`.
- `RD_MASK`, `'b0001` — bit i = 1: port i is an FX3→FPGA read port (`SLOEn_o` low while granted).
- `SKIP_IDLE`, 1 — 1: ports with `req_i[i]` = 0 are skipped; 0: every port is visited in order regardless of `req_i` (legacy sequence).
- `TIMEOUT`, 0 — watchdog limit in cycles in WT_DONE; 0 disables.

Ports:
- `clk_i`  in  1  — system clock.
- `rstn_i`  in  1  — synchronous reset, active-low.
- `req_i`  in  NUM_DP  — port i has work pending; level.
- `strt_o`  out  NUM_DP  — one-hot, one-cycle start pulse to the granted engine.
- `done_i`  in  NUM_DP  — granted engine finished; one-cycle pulse.
- `grant_o`  out  NUM_DP  — one-hot current owner, 0 when none.
- `tmo_o`  out  1  — one-cycle pulse on watchdog expiry.
- `SLWRn_i`  in  NUM_DP  — per-engine write strobe, active-low.
- `PKTENDn_i`  in  NUM_DP  — per-engine packet end, active-low.
- `SLADDR_o`  out  ADDR_W  — FX3 endpoint address; equals the granted port index.
- `SLOEn_o`  out  1  — FX3 output enable, active-low.
- `SLCSn_o`  out  1  — FX3 chip select, active-low.
- `SLWRn_o`  out  1  — muxed write strobe.
- `PKTENDn_o`  out  1  — muxed packet end.

## Operation
- States:
  - IDLE: one cycle after reset, then → ARB.
  - ARB: if a candidate exists → STRT, else stay.
  - STRT: one cycle → WT_DONE.
  - WT_DONE: `done_i[g]` → ARB; watchdog expiry → ARB.
- Candidate search starts at `(last_grant+1) mod NUM_DP` and wraps.
  - SKIP_IDLE=1: first port with `req_i` high.
  - SKIP_IDLE=0: next port unconditionally; `req_i` is ignored.
- `last_grant` resets to `NUM_DP-1`, so port 0 is first. It updates on ARB→STRT.
- Grant register `g` is loaded on ARB→STRT and cleared on WT_DONE→ARB.
- `done_i` is sampled only in WT_DONE and only for bit g. All other `done_i` bits, and `done_i` in STRT, are ignored.
- Deassertion of `req_i[g]` during STRT/WT_DONE is ignored; the transfer runs to done or timeout.
- Watchdog: counter cleared in STRT, increments each WT_DONE cycle. When count reaches TIMEOUT without done, `tmo_o` pulses and the FSM goes to ARB.
  - Done and expiry in the same cycle: done wins, no `tmo_o`.
- Outputs while granted (STRT, WT_DONE):
  - `SLCSn_o`=0.
  - `SLADDR_o`=g.
  - `SLOEn_o`=~`RD_MASK[g]`.
  - `grant_o`=1<<g.
  - `SLWRn_o`=`SLWRn_i[g]`, `PKTENDn_o`=`PKTENDn_i[g]`.
- `strt_o`=1<<g in STRT only.
- Outputs while ungranted (IDLE, ARB): `SLCSn_o`=1, `SLOEn_o`=1, `SLADDR_o`=0, `SLWRn_o`=1, `PKTENDn_o`=1, `grant_o`=0, `strt_o`=0.

## Timing
- Reset: state IDLE, g cleared, counter 0, `tmo_o`=0. All outputs take their ungranted values in the cycle after `rstn_i` is sampled low.
- Reset mid-transfer: bus released next cycle; no `strt_o`/`tmo_o` emitted.
- `req_i` high in ARB cycle N: `strt_o` and `grant_o` valid in cycle N+1.
- `done_i` in cycle M: `grant_o`=0 and `SLCSn_o`=1 in cycle M+1.
  - Minimum one ARB cycle between grants, so the FX3 sees one deselected cycle at every port switch.
- Control outputs (`strt_o`, `grant_o`, `SLADDR_o`, `SLOEn_o`, `SLCSn_o`, `tmo_o`) are decoded from registered state and g only.
- `SLWRn_o`/`PKTENDn_o` are a combinational mux from inputs, gated by the grant: zero-cycle path, one mux level.

## Structure
- Shared package `usb_if_pkg`: state encodings (IDLE=0, ARB=1, STRT=2, WT_DONE=3) and the `NUM_DP` range limits.
- One sub-module, `rr_pick`: a combinational rotate-priority encoder.
  - Inputs: request vector and pointer.
  - Outputs: valid flag and index.
  - Reusable by the register-bank arbiter.

## Test plan
- NUM_DP=4, SKIP_IDLE=0, all `done_i` returned 3 cycles after `strt_o`: grant order 0,1,2,3,0.
  - `SLOEn_o`=0 only while port 0 is granted (`RD_MASK`=`'b0001`).
  - `SLADDR_o` tracks g.
- SKIP_IDLE=1, `req_i`=`'b1010` held: grants alternate 1,3,1,3.
  - `req_i`=0: stays in ARB with `SLCSn_o`=1 indefinitely.
- Last grant was 2, then `req_i`=`'b0101`: next grant is 0 (wrap).
  - Wrong-bit `done_i[1]` during port-0 grant is ignored.
- TIMEOUT=16, no done:
  - `tmo_o` pulses exactly 16 cycles after STRT; arbitration resumes with the next port.
  - Repeated with `done_i` on the expiry cycle: no `tmo_o`.
- `rstn_i` low during WT_DONE with `SLWRn_i[g]`=0: next cycle `SLWRn_o`=1, `SLCSn_o`=1, `grant_o`=0.
  - After release, first grant is port 0.
